rs_alu: RTL and testbench
=========================

# rs_alu

Reservation station feeding the ALU in the Tomasulo core. It accepts decoded ALU/branch/jump instructions from dispatch and holds them until both source operands are available. It snoops the ALU and LSB result broadcasts to capture pending operands, then issues one ready instruction per cycle to the combinational ALU through a registered issue port. The ALU's broadcast then closes the loop back into this block's snoop inputs.

## Interface
Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..32)
- TAG_W, 4, ROB entry tag width (matches `ENTRY_RANGE`)

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global ready; low = freeze all state
- flush_in  in  1  misprediction clear
- disp_valid  in  1  dispatch request
- disp_instruction / disp_pc / disp_imm  in  32 each  raw instruction, PC, decoded immediate
- disp_op  in  6  ALU opcode
- disp_qj_busy, disp_qk_busy  in  1 each  operand still pending
- disp_qj, disp_qk  in  TAG_W each  producer ROB tags
- disp_vj, disp_vk  in  32 each  operand values (valid when not busy)
- disp_entry  in  TAG_W  destination ROB tag
- rs_full  out  1  no free entry (combinational)
- alu_broadcast_in / lsb_broadcast_in  in  1 each  CDB valid
- alu_result_in / lsb_result_in  in  32 each  CDB value
- alu_entry_in / lsb_entry_in  in  TAG_W each  CDB tag
- new_calculate  out  1  one-cycle issue strobe to ALU
- instruction, pc, imm, vj, vk  out  32 each  issued fields
- op  out  6  issued opcode
- entry  out  TAG_W  issued ROB tag

## Operation
- Each entry holds: busy, op, instruction, pc, imm, qj_busy, qj, vj, qk_busy, qk, vk, entry.
- Dispatch: when disp_valid && !rs_full, write the lowest-index non-busy entry. Dispatch while rs_full is dropped (upstream violation, no state change).
- Dispatch bypass: if disp_qj_busy and a broadcast in the same cycle carries tag disp_qj, store qj_busy=0 and capture the broadcast value. Apply the same rule to qk.
- Snoop: every busy entry with qj_busy and qj == broadcast tag clears qj_busy and loads the value. Apply the same rule to qk. Both CDBs are checked in parallel. If both carry the same tag, the ALU value wins.
- Ready means busy && !qj_busy && !qk_busy, evaluated on registered state only. A same-cycle wakeup does not make an entry ready in that cycle.
- Select: the lowest-index ready entry is issued. Its fields are registered onto the issue outputs, new_calculate=1, and its busy bit is cleared.
- Entry reuse: an entry freed by issue cannot be refilled in the same cycle. rs_full is computed from the pre-issue busy vector.
- Flush: clears every busy bit and forces new_calculate=0 at the next edge. Flush has priority over dispatch, snoop and issue.
- rdy_in low: no dispatch, snoop or issue takes effect, all entries hold, and new_calculate=0 at the next edge. Broadcasts arriving while rdy_in is low are lost; upstream holds them.

## Timing
- Reset (async, rst_n_in=0): all busy=0, new_calculate=0, and op, instruction, pc, imm, vj, vk, entry all 0. rs_full=0.
- Issue outputs are registered. They are valid for exactly the cycle new_calculate=1, which never lasts more than one consecutive cycle per entry.
- Minimum latency is two edges. If dispatch with both operands ready is sampled at edge E0, new_calculate is high after E1.
- Wakeup: a broadcast sampled at edge Ek makes a waiting entry ready after Ek. Issue then follows after Ek+1.
- Throughput is one issue per cycle. A sustained stream of ready dispatches occupies one entry in steady state.
- Full boundary: rs_full=1 exactly when all RS_SIZE busy bits are 1. rs_full deasserts in the cycle after an issue edge.
- Reset mid-operation discards all entries immediately and drives the outputs to their reset values asynchronously.

## Test plan
- Ready dispatch: op=ADD, vj=5, vk=7, entry=3, no pending operands → after the 2nd edge, new_calculate=1 for one cycle with vj=5, vk=7, entry=3; the ALU broadcasts 12.
- Wakeup: dispatch with qj_busy, qj=6, vk=1; then alu_broadcast_in with tag 6, value 0x10 → issue two edges later with vj=0x10, vk=1. With no broadcast, the entry never issues.
- Dispatch bypass: disp_qk_busy, qk=2, while lsb_broadcast_in tag 2 carries 0xABCD in the same cycle → the entry issues two edges later with vk=0xABCD.
- Fill and drain: dispatch 16 entries all waiting on tag 9 → rs_full=1 and a 17th dispatch is dropped; broadcast tag 9 → issues follow in index order 0..15, one per cycle, and rs_full drops after the first issue.
- Flush: 4 entries present with one issuing this cycle, then assert flush_in → new_calculate=0 next cycle, all busy cleared, rs_full=0, and no later issue.
- Reset/rdy_in: drop rst_n_in mid-issue → outputs go to 0 immediately. Hold rdy_in=0 with a ready entry → no issue until rdy_in returns to 1, then issue on the following edge.

Source files
------------

// File: rtl/rs_alu_if.sv
// ----------------------------------------------------------------------------
// rs_alu_if
// Bus bundle between the ALU reservation station and its neighbours.
//
// Groups three traffic classes:
//   dispatch : disp_valid plus the decoded instruction fields and operand
//              state (disp_*), with rs_full reported back to dispatch.
//   snoop    : the ALU and LSB common data buses (alu_*_in, lsb_*_in).
//   issue    : new_calculate strobe and the registered instruction fields
//              (instruction, pc, imm, vj, vk, op, entry) sent to the ALU.
//
// Modports:
//   master : the surrounding core (drives dispatch and broadcasts,
//            observes rs_full and the issue port).
//   slave  : the reservation station itself.
// ----------------------------------------------------------------------------
interface rs_alu_if #(
    parameter int TAG_W = 4
);
    // Dispatch side
    logic             disp_valid;
    logic [31:0]      disp_instruction;
    logic [31:0]      disp_pc;
    logic [31:0]      disp_imm;
    logic [5:0]       disp_op;
    logic             disp_qj_busy;
    logic             disp_qk_busy;
    logic [TAG_W-1:0] disp_qj;
    logic [TAG_W-1:0] disp_qk;
    logic [31:0]      disp_vj;
    logic [31:0]      disp_vk;
    logic [TAG_W-1:0] disp_entry;
    logic             rs_full;

    // Common data buses
    logic             alu_broadcast_in;
    logic [31:0]      alu_result_in;
    logic [TAG_W-1:0] alu_entry_in;
    logic             lsb_broadcast_in;
    logic [31:0]      lsb_result_in;
    logic [TAG_W-1:0] lsb_entry_in;

    // Issue port towards the ALU
    logic             new_calculate;
    logic [31:0]      instruction;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [5:0]       op;
    logic [TAG_W-1:0] entry;

    modport master (
        output disp_valid, disp_instruction, disp_pc, disp_imm, disp_op,
               disp_qj_busy, disp_qk_busy, disp_qj, disp_qk,
               disp_vj, disp_vk, disp_entry,
               alu_broadcast_in, alu_result_in, alu_entry_in,
               lsb_broadcast_in, lsb_result_in, lsb_entry_in,
        input  rs_full,
               new_calculate, instruction, pc, imm, vj, vk, op, entry
    );

    modport slave (
        input  disp_valid, disp_instruction, disp_pc, disp_imm, disp_op,
               disp_qj_busy, disp_qk_busy, disp_qj, disp_qk,
               disp_vj, disp_vk, disp_entry,
               alu_broadcast_in, alu_result_in, alu_entry_in,
               lsb_broadcast_in, lsb_result_in, lsb_entry_in,
        output rs_full,
               new_calculate, instruction, pc, imm, vj, vk, op, entry
    );
endinterface

// File: rtl/rs_alu.sv
// ----------------------------------------------------------------------------
// rs_alu
// Reservation station in front of the combinational ALU of the Tomasulo core.
// Holds dispatched ALU/branch/jump instructions until both source operands
// are known, snoops the ALU and LSB result buses for pending operands and
// issues at most one ready instruction per cycle through a registered port.
//
// Parameters:
//   RS_SIZE : number of entries (power of two, 2..32)
//   TAG_W   : ROB tag width
//
// Ports:
//   clk_in   : clock
//   rst_n_in : asynchronous active-low reset
//   rdy_in   : global ready, low freezes all state
//   flush_in : misprediction clear of every entry
//   bus      : rs_alu_if slave (dispatch, snoop buses, issue port, rs_full)
// ----------------------------------------------------------------------------
module rs_alu #(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = 4
) (
    input  logic     clk_in,
    input  logic     rst_n_in,
    input  logic     rdy_in,
    input  logic     flush_in,
    rs_alu_if.slave  bus
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic [5:0]       op;
        logic [31:0]      instruction;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic             qj_busy;
        logic [TAG_W-1:0] qj;
        logic [31:0]      vj;
        logic             qk_busy;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vk;
        logic [TAG_W-1:0] entry;
    } slot_t;

    typedef struct packed {
        logic [5:0]       op;
        logic [31:0]      instruction;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] entry;
    } issue_t;

    logic [RS_SIZE-1:0] busy;
    slot_t              slots [RS_SIZE];
    issue_t             issue_q;
    logic               new_calc_q;

    logic [RS_SIZE-1:0] ready_vec;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               issue_found;
    logic [IDX_W-1:0]   issue_idx;

    logic               qj_busy_next [RS_SIZE];
    logic [31:0]        vj_next      [RS_SIZE];
    logic               qk_busy_next [RS_SIZE];
    logic [31:0]        vk_next      [RS_SIZE];

    logic               disp_qj_busy_eff;
    logic [31:0]        disp_vj_eff;
    logic               disp_qk_busy_eff;
    logic [31:0]        disp_vk_eff;
    slot_t              disp_slot;

    // Resolves one operand against both result buses. The ALU bus is checked
    // first so that it wins when both buses carry the same tag.
    function automatic logic [32:0] capture(
        input logic             pending,
        input logic [TAG_W-1:0] tag,
        input logic [31:0]      value,
        input logic             alu_v,
        input logic [TAG_W-1:0] alu_t,
        input logic [31:0]      alu_d,
        input logic             lsb_v,
        input logic [TAG_W-1:0] lsb_t,
        input logic [31:0]      lsb_d
    );
        capture = {pending, value};
        if (pending) begin
            if (alu_v && (alu_t == tag)) begin
                capture = {1'b0, alu_d};
            end else if (lsb_v && (lsb_t == tag)) begin
                capture = {1'b0, lsb_d};
            end
        end
    endfunction

    // Readiness only looks at registered operand state, so a wakeup in this
    // cycle makes the entry eligible one edge later.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy[i] & ~slots[i].qj_busy & ~slots[i].qk_busy;
        end
    end

    // Priority encoders: scanning from the top down lets the lowest index
    // overwrite any higher match.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready_vec[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end

    // Snoop results for every entry; only applied to busy entries below.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            {qj_busy_next[i], vj_next[i]} = capture(
                slots[i].qj_busy, slots[i].qj, slots[i].vj,
                bus.alu_broadcast_in, bus.alu_entry_in, bus.alu_result_in,
                bus.lsb_broadcast_in, bus.lsb_entry_in, bus.lsb_result_in);
            {qk_busy_next[i], vk_next[i]} = capture(
                slots[i].qk_busy, slots[i].qk, slots[i].vk,
                bus.alu_broadcast_in, bus.alu_entry_in, bus.alu_result_in,
                bus.lsb_broadcast_in, bus.lsb_entry_in, bus.lsb_result_in);
        end
    end

    // Dispatch bypass: an operand whose producer broadcasts in the same
    // cycle is captured directly instead of waiting for a broadcast that has
    // already gone by.
    always_comb begin
        {disp_qj_busy_eff, disp_vj_eff} = capture(
            bus.disp_qj_busy, bus.disp_qj, bus.disp_vj,
            bus.alu_broadcast_in, bus.alu_entry_in, bus.alu_result_in,
            bus.lsb_broadcast_in, bus.lsb_entry_in, bus.lsb_result_in);
        {disp_qk_busy_eff, disp_vk_eff} = capture(
            bus.disp_qk_busy, bus.disp_qk, bus.disp_vk,
            bus.alu_broadcast_in, bus.alu_entry_in, bus.alu_result_in,
            bus.lsb_broadcast_in, bus.lsb_entry_in, bus.lsb_result_in);

        disp_slot.op          = bus.disp_op;
        disp_slot.instruction = bus.disp_instruction;
        disp_slot.pc          = bus.disp_pc;
        disp_slot.imm         = bus.disp_imm;
        disp_slot.qj_busy     = disp_qj_busy_eff;
        disp_slot.qj          = bus.disp_qj;
        disp_slot.vj          = disp_vj_eff;
        disp_slot.qk_busy     = disp_qk_busy_eff;
        disp_slot.qk          = bus.disp_qk;
        disp_slot.vk          = disp_vk_eff;
        disp_slot.entry       = bus.disp_entry;
    end

    // Main state update. rdy_in low freezes everything except the issue
    // strobe, which drops so nothing is issued twice. Flush wins over all
    // other activity. The issued slot and the dispatch slot can never
    // coincide because one is busy and the other is free, and the free slot
    // is chosen from the pre-issue busy vector.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy       <= '0;
            new_calc_q <= 1'b0;
            issue_q    <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                slots[i] <= '0;
            end
        end else if (!rdy_in) begin
            new_calc_q <= 1'b0;
        end else if (flush_in) begin
            busy       <= '0;
            new_calc_q <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    slots[i].qj_busy <= qj_busy_next[i];
                    slots[i].vj      <= vj_next[i];
                    slots[i].qk_busy <= qk_busy_next[i];
                    slots[i].vk      <= vk_next[i];
                end
            end

            new_calc_q <= issue_found;
            if (issue_found) begin
                issue_q.op          <= slots[issue_idx].op;
                issue_q.instruction <= slots[issue_idx].instruction;
                issue_q.pc          <= slots[issue_idx].pc;
                issue_q.imm         <= slots[issue_idx].imm;
                issue_q.vj          <= slots[issue_idx].vj;
                issue_q.vk          <= slots[issue_idx].vk;
                issue_q.entry       <= slots[issue_idx].entry;
                busy[issue_idx]     <= 1'b0;
            end

            if (bus.disp_valid && free_found) begin
                busy[free_idx]  <= 1'b1;
                slots[free_idx] <= disp_slot;
            end
        end
    end

    assign bus.rs_full       = &busy;
    assign bus.new_calculate = new_calc_q;
    assign bus.op            = issue_q.op;
    assign bus.instruction   = issue_q.instruction;
    assign bus.pc            = issue_q.pc;
    assign bus.imm           = issue_q.imm;
    assign bus.vj            = issue_q.vj;
    assign bus.vk            = issue_q.vk;
    assign bus.entry         = issue_q.entry;

endmodule

// File: tb/tb_rs_alu.sv
// ----------------------------------------------------------------------------
// tb_rs_alu
// Directed self-checking bench for rs_alu (RS_SIZE=16, TAG_W=4).
// Dispatched instructions carry fields derived from their ROB tag:
//   instruction = 0xA000_0000 | tag, pc = 0x1000 + 4*tag, imm = 0x100 + tag
// ----------------------------------------------------------------------------
module tb_rs_alu;

    logic clk;
    logic rst_n;
    logic rdy;
    logic flush;

    int assertions_count = 0;
    int fail_count       = 0;

    rs_alu_if #(.TAG_W(4)) bus ();

    rs_alu #(
        .RS_SIZE (16),
        .TAG_W   (4)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_valid       = 1'b0;
        bus.disp_instruction = '0;
        bus.disp_pc          = '0;
        bus.disp_imm         = '0;
        bus.disp_op          = '0;
        bus.disp_qj_busy     = 1'b0;
        bus.disp_qk_busy     = 1'b0;
        bus.disp_qj          = '0;
        bus.disp_qk          = '0;
        bus.disp_vj          = '0;
        bus.disp_vk          = '0;
        bus.disp_entry       = '0;
        bus.alu_broadcast_in = 1'b0;
        bus.alu_result_in    = '0;
        bus.alu_entry_in     = '0;
        bus.lsb_broadcast_in = 1'b0;
        bus.lsb_result_in    = '0;
        bus.lsb_entry_in     = '0;
    endtask

    task automatic apply_stimulus(
        input logic [5:0]  op,
        input logic        qj_busy,
        input logic [3:0]  qj,
        input logic [31:0] vj,
        input logic        qk_busy,
        input logic [3:0]  qk,
        input logic [31:0] vk,
        input logic [3:0]  tag
    );
        bus.disp_valid       = 1'b1;
        bus.disp_op          = op;
        bus.disp_qj_busy     = qj_busy;
        bus.disp_qj          = qj;
        bus.disp_vj          = vj;
        bus.disp_qk_busy     = qk_busy;
        bus.disp_qk          = qk;
        bus.disp_vk          = vk;
        bus.disp_entry       = tag;
        bus.disp_instruction = 32'hA000_0000 | 32'(tag);
        bus.disp_pc          = 32'h0000_1000 + 32'(tag) * 4;
        bus.disp_imm         = 32'h0000_0100 + 32'(tag);
    endtask

    task automatic alu_cdb(input logic [3:0] tag, input logic [31:0] value);
        bus.alu_broadcast_in = 1'b1;
        bus.alu_entry_in     = tag;
        bus.alu_result_in    = value;
    endtask

    task automatic lsb_cdb(input logic [3:0] tag, input logic [31:0] value);
        bus.lsb_broadcast_in = 1'b1;
        bus.lsb_entry_in     = tag;
        bus.lsb_result_in    = value;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assertions_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        flush = 1'b0;
        idle_inputs();

        // Reset state
        #12;
        check_output("reset_new_calc", 32'(bus.new_calculate), 32'd0);
        check_output("reset_rs_full",  32'(bus.rs_full),       32'd0);
        check_output("reset_vj",       bus.vj,                 32'd0);
        check_output("reset_pc",       bus.pc,                 32'd0);
        check_output("reset_entry",    32'(bus.entry),         32'd0);
        check_output("reset_op",       32'(bus.op),            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_output("post_reset_new_calc", 32'(bus.new_calculate), 32'd0);

        // Ready dispatch: ADD 5 + 7 to ROB tag 3, issue after the second edge
        $display("[TB] ready dispatch");
        apply_stimulus(6'h01, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
        tick();
        check_output("t1_no_issue_e0", 32'(bus.new_calculate), 32'd0);
        idle_inputs();
        tick();
        check_output("t1_new_calc", 32'(bus.new_calculate), 32'd1);
        check_output("t1_vj",       bus.vj,                 32'd5);
        check_output("t1_vk",       bus.vk,                 32'd7);
        check_output("t1_entry",    32'(bus.entry),         32'd3);
        check_output("t1_op",       32'(bus.op),            32'h01);
        check_output("t1_instr",    bus.instruction,        32'hA000_0003);
        check_output("t1_pc",       bus.pc,                 32'h0000_100C);
        check_output("t1_imm",      bus.imm,                32'h0000_0103);
        alu_cdb(4'd3, 32'd12);
        tick();
        check_output("t1_one_cycle", 32'(bus.new_calculate), 32'd0);
        idle_inputs();

        // Wakeup on tag 6; both buses carry tag 6 and the ALU value wins
        $display("[TB] wakeup");
        apply_stimulus(6'h02, 1'b1, 4'd6, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd1, 4'd4);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t2_waiting", 32'(bus.new_calculate), 32'd0);
        end
        alu_cdb(4'd6, 32'h10);
        lsb_cdb(4'd6, 32'h99);
        tick();
        check_output("t2_no_same_cycle_issue", 32'(bus.new_calculate), 32'd0);
        idle_inputs();
        tick();
        check_output("t2_new_calc", 32'(bus.new_calculate), 32'd1);
        check_output("t2_vj",       bus.vj,                 32'h10);
        check_output("t2_vk",       bus.vk,                 32'd1);
        check_output("t2_entry",    32'(bus.entry),         32'd4);

        // Dispatch bypass from the LSB bus on qk
        $display("[TB] dispatch bypass");
        apply_stimulus(6'h03, 1'b0, 4'd0, 32'h20, 1'b1, 4'd2, 32'h0, 4'd5);
        lsb_cdb(4'd2, 32'hABCD);
        tick();
        check_output("t3_no_issue_e0", 32'(bus.new_calculate), 32'd0);
        idle_inputs();
        tick();
        check_output("t3_new_calc", 32'(bus.new_calculate), 32'd1);
        check_output("t3_vk",       bus.vk,                 32'hABCD);
        check_output("t3_vj",       bus.vj,                 32'h20);
        check_output("t3_entry",    32'(bus.entry),         32'd5);
        tick();
        check_output("t3_one_cycle", 32'(bus.new_calculate), 32'd0);

        // Fill and drain: 16 entries waiting on tag 9
        $display("[TB] fill and drain");
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                check_output("t4_not_full_at_15", 32'(bus.rs_full), 32'd0);
            end
            apply_stimulus(6'h04, 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'(i), 4'(i));
            tick();
        end
        check_output("t4_full", 32'(bus.rs_full), 32'd1);
        apply_stimulus(6'h05, 1'b0, 4'd0, 32'hDEAD, 1'b0, 4'd0, 32'h0, 4'd0);
        tick();
        check_output("t4_drop_no_issue", 32'(bus.new_calculate), 32'd0);
        check_output("t4_still_full",    32'(bus.rs_full),       32'd1);
        idle_inputs();
        alu_cdb(4'd9, 32'h99);
        tick();
        check_output("t4_wake_no_issue", 32'(bus.new_calculate), 32'd0);
        check_output("t4_full_at_wake",  32'(bus.rs_full),       32'd1);
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            tick();
            check_output("t4_drain_new_calc", 32'(bus.new_calculate), 32'd1);
            check_output("t4_drain_entry",    32'(bus.entry),         32'(i));
            check_output("t4_drain_vk",       bus.vk,                 32'(i));
            check_output("t4_drain_vj",       bus.vj,                 32'h99);
            check_output("t4_drain_not_full", 32'(bus.rs_full),       32'd0);
        end
        tick();
        check_output("t4_drained", 32'(bus.new_calculate), 32'd0);

        // Flush with three waiting entries and one ready to issue
        $display("[TB] flush");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(6'h06, 1'b1, 4'd7, 32'h0, 1'b0, 4'd0, 32'h0, 4'(10 + i));
            tick();
        end
        apply_stimulus(6'h07, 1'b0, 4'd0, 32'h42, 1'b0, 4'd0, 32'h0, 4'd13);
        tick();
        flush = 1'b1;
        apply_stimulus(6'h08, 1'b0, 4'd0, 32'h43, 1'b0, 4'd0, 32'h0, 4'd14);
        alu_cdb(4'd7, 32'h77);
        tick();
        flush = 1'b0;
        check_output("t5_flush_new_calc", 32'(bus.new_calculate), 32'd0);
        check_output("t5_flush_rs_full",  32'(bus.rs_full),       32'd0);
        idle_inputs();
        alu_cdb(4'd7, 32'h77);
        tick();
        check_output("t5_after_flush", 32'(bus.new_calculate), 32'd0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t5_no_later_issue", 32'(bus.new_calculate), 32'd0);
        end

        // Asynchronous reset while an issue is on the port
        $display("[TB] reset mid-issue");
        apply_stimulus(6'h09, 1'b0, 4'd0, 32'h55, 1'b0, 4'd0, 32'h66, 4'd7);
        tick();
        idle_inputs();
        tick();
        check_output("t6_issue", 32'(bus.new_calculate), 32'd1);
        check_output("t6_vj",    bus.vj,                 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_new_calc", 32'(bus.new_calculate), 32'd0);
        check_output("t6_rst_vj",       bus.vj,                 32'd0);
        check_output("t6_rst_vk",       bus.vk,                 32'd0);
        check_output("t6_rst_entry",    32'(bus.entry),         32'd0);
        check_output("t6_rst_op",       32'(bus.op),            32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        check_output("t6_after_rst", 32'(bus.new_calculate), 32'd0);

        // rdy_in low holds a ready entry and drops a new dispatch
        $display("[TB] rdy stall");
        apply_stimulus(6'h0A, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'h0, 4'd8);
        tick();
        rdy = 1'b0;
        apply_stimulus(6'h0B, 1'b0, 4'd0, 32'h88, 1'b0, 4'd0, 32'h0, 4'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t7_stalled", 32'(bus.new_calculate), 32'd0);
        end
        idle_inputs();
        rdy = 1'b1;
        tick();
        check_output("t7_resume_new_calc", 32'(bus.new_calculate), 32'd1);
        check_output("t7_resume_entry",    32'(bus.entry),         32'd8);
        check_output("t7_resume_vj",       bus.vj,                 32'h77);
        tick();
        check_output("t7_stalled_disp_dropped", 32'(bus.new_calculate), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_count, fail_count);
        $finish;
    end

endmodule
